// File: rtl/hfifo_bank.sv
// hfifo_bank: NCH-lane lockstep FIFO bank with shared pointers, occupancy flags and sticky errors.
// Define HFIFO_SKEW_EN to delay lane k by k extra stages for diagonal wavefront injection.
module hfifo_bank #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [NCH*WIDTH-1:0]   din,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic [NCH-1:0]         valid_o,
  output logic [$clog2(DEPTH):0] count,
  output logic                   f,
  output logic                   af,
  output logic                   e,
  output logic                   ae,
  output logic                   ovf,
  output logic                   udf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

  logic [NCH*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        count_nxt;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [NCH*WIDTH-1:0] dout_p0;
  logic                 vld_p0;

  assign f  = (count == FULL_LVL);
  assign e  = (count == '0);
  assign af = (count >= AF_LVL);
  assign ae = (count <= AE_LVL);

  // A simultaneous read frees a slot, so a full FIFO still takes the write.
  assign wr_acc = en & wr & (~f | rd);
  assign rd_acc = en & rd & ~e;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (en) begin
      if (wr_acc)
        wptr <= wptr + AW'(1);
      if (rd_acc)
        rptr <= rptr + AW'(1);
      count <= count_nxt;
      if (wr && f && !rd)
        ovf <= 1'b1;
      if (rd && e)
        udf <= 1'b1;
    end
  end

  // Stage p0: registered read port, shared by all lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (en) begin
      vld_p0 <= rd_acc;
      if (rd_acc)
        dout_p0 <= mem[rptr];
    end
  end

`ifdef HFIFO_SKEW_EN
  // Stage p1..pk: lane k is delayed by k registers; bubbles shift through as valid=0
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    if (k == 0) begin : g_direct
      assign dout[WIDTH-1:0] = dout_p0[WIDTH-1:0];
      assign valid_o[0]      = vld_p0;
    end else begin : g_skew
      logic [WIDTH-1:0] dat_p1 [k];
      logic             vld_p1 [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < k; s++) begin
            dat_p1[s] <= '0;
            vld_p1[s] <= 1'b0;
          end
        end else if (en) begin
          dat_p1[0] <= dout_p0[k*WIDTH +: WIDTH];
          vld_p1[0] <= vld_p0;
          for (int s = 1; s < k; s++) begin
            dat_p1[s] <= dat_p1[s-1];
            vld_p1[s] <= vld_p1[s-1];
          end
        end
      end

      assign dout[k*WIDTH +: WIDTH] = dat_p1[k-1];
      assign valid_o[k]             = vld_p1[k-1];
    end
  end
`else
  assign dout    = dout_p0;
  assign valid_o = {NCH{vld_p0}};
`endif

endmodule

// File: tb/tb_hfifo_bank.sv
// Self-checking bench for hfifo_bank: queue reference model plus scoreboard of read data,
// a table of short single-cycle vectors, and hand sequences for fill/drain/wrap/reset/skew.
module tb_hfifo_bank;
  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
`ifdef HFIFO_SKEW_EN
  localparam logic [63:0] DMASK = 64'h0000_0000_0000_FFFF;
  localparam logic [3:0]  VMASK = 4'b0001;
`else
  localparam logic [63:0] DMASK = '1;
  localparam logic [3:0]  VMASK = 4'b1111;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr;
  logic        rd;
  logic [63:0] din;
  logic [63:0] dout;
  logic [3:0]  valid_o;
  logic [5:0]  count;
  logic        f, af, e, ae, ovf, udf;

  int total = 0;
  int bad   = 0;

  logic [63:0] model[$];
  logic [63:0] exp_q[$];
  logic        m_vld;
  logic        m_ovf;
  logic        m_udf;
  logic [63:0] m_dout;

  typedef struct {
    logic en;
    logic wr;
    logic rd;
    int   cnt;
    logic ee;
    logic ae;
    logic v;
    logic udf;
  } vec_t;
  vec_t tbl[8];

  hfifo_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .rd(rd), .din(din),
    .dout(dout), .valid_o(valid_o), .count(count),
    .f(f), .af(af), .e(e), .ae(ae), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] dat(input int i);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < NCH; k++)
      d[k*WIDTH +: WIDTH] = 16'(i + 1 + k * 256);
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare everything at posedge+1.
  task automatic step(input logic e_i, input logic w_i, input logic r_i, input logic [63:0] d);
    logic full, empty, pushed;
    en = e_i; wr = w_i; rd = r_i; din = d;
    full   = (model.size() == DEPTH);
    empty  = (model.size() == 0);
    pushed = 1'b0;
    if (e_i) begin
      m_vld = 1'b0;
      if (r_i && !empty) begin
        exp_q.push_back(model.pop_front());
        m_vld  = 1'b1;
        pushed = 1'b1;
      end
      if (w_i && (!full || r_i)) model.push_back(d);
      if (w_i && full && !r_i) m_ovf = 1'b1;
      if (r_i && empty) m_udf = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pushed) m_dout = exp_q.pop_front();
    chk("dout",  dout & DMASK, m_dout & DMASK);
    chk("valid", 64'(valid_o & VMASK), 64'({NCH{m_vld}} & VMASK));
    chk("count", 64'(count), 64'(model.size()));
    chk("full",  64'(f),  64'(model.size() == DEPTH));
    chk("empty", 64'(e),  64'(model.size() == 0));
    chk("afull", 64'(af), 64'(model.size() >= DEPTH - 2));
    chk("aempty",64'(ae), 64'(model.size() <= 2));
    chk("ovf",   64'(ovf), 64'(m_ovf));
    chk("udf",   64'(udf), 64'(m_udf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; wr = 1'b0; rd = 1'b0;
    model.delete();
    exp_q.delete();
    m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_e",     64'(e),     64'd1);
    chk("rst_ae",    64'(ae),    64'd1);
    chk("rst_f",     64'(f),     64'd0);
    chk("rst_af",    64'(af),    64'd0);
    chk("rst_dout",  dout,       64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ovf",   64'(ovf),   64'd0);
    chk("rst_udf",   64'(udf),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp0;
    tbl[0] = '{en:1, wr:0, rd:1, cnt:0, ee:1, ae:1, v:0, udf:1};
    tbl[1] = '{en:1, wr:1, rd:1, cnt:1, ee:0, ae:1, v:0, udf:1};
    tbl[2] = '{en:1, wr:1, rd:0, cnt:2, ee:0, ae:1, v:0, udf:1};
    tbl[3] = '{en:1, wr:1, rd:0, cnt:3, ee:0, ae:0, v:0, udf:1};
    tbl[4] = '{en:0, wr:1, rd:1, cnt:3, ee:0, ae:0, v:0, udf:1};
    tbl[5] = '{en:1, wr:1, rd:1, cnt:3, ee:0, ae:0, v:1, udf:1};
    tbl[6] = '{en:1, wr:0, rd:1, cnt:2, ee:0, ae:1, v:1, udf:1};
    tbl[7] = '{en:1, wr:0, rd:0, cnt:2, ee:0, ae:1, v:0, udf:1};
    din = '0;

    // Reset values
    do_reset();

    // Fill past full
    for (int i = 0; i < 34; i++) begin
      step(1'b1, 1'b1, 1'b0, dat(i));
      if (i == 28) chk("af_at29", 64'(af), 64'd0);
      if (i == 29) begin
        chk("cnt_at30", 64'(count), 64'd30);
        chk("af_at30",  64'(af),    64'd1);
      end
      if (i == 30) chk("f_at31", 64'(f), 64'd0);
      if (i == 31) chk("f_at32", 64'(f), 64'd1);
    end
    chk("ovf_fill", 64'(ovf), 64'd1);
    chk("cnt_fill", 64'(count), 64'd32);

    // Drain past empty
    for (int j = 0; j < 34; j++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      if (j < 32) begin
        chk("drain_lane0", 64'(dout[15:0]), 64'(j + 1));
        chk("drain_vld",   64'(valid_o[0]), 64'd1);
      end else begin
        chk("drain_vld_empty", 64'(valid_o[0]), 64'd0);
        chk("drain_udf",       64'(udf),        64'd1);
      end
      if (j == 31) chk("drain_e", 64'(e), 64'd1);
    end

    // Pointer wrap: 20 in, 10 out, 20 in, 30 out
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, dat(i));
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk("wrap_a", 64'(dout[15:0]), 64'(j + 1));
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, dat(i));
    chk("wrap_cnt", 64'(count), 64'd30);
    for (int j = 0; j < 30; j++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      exp0 = (j < 10) ? (j + 11) : (j - 9);
      chk("wrap_b", 64'(dout[15:0]), 64'(exp0));
    end

    // Table vectors from empty
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].wr, tbl[i].rd, dat(100 + i));
      chk("tbl_cnt", 64'(count),      64'(tbl[i].cnt));
      chk("tbl_e",   64'(e),          64'(tbl[i].ee));
      chk("tbl_ae",  64'(ae),         64'(tbl[i].ae));
      chk("tbl_v",   64'(valid_o[0]), 64'(tbl[i].v));
      chk("tbl_udf", 64'(udf),        64'(tbl[i].udf));
    end

    // Full with simultaneous read and write
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0, dat(i));
    step(1'b1, 1'b1, 1'b1, dat(200));
    chk("frw_cnt1",  64'(count),      64'd32);
    chk("frw_dout1", 64'(dout[15:0]), 64'd1);
    step(1'b1, 1'b1, 1'b1, dat(201));
    chk("frw_cnt2",  64'(count),      64'd32);
    chk("frw_dout2", 64'(dout[15:0]), 64'd2);
    chk("frw_ovf",   64'(ovf),        64'd0);

    // Freeze with EN=0, then asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, dat(i));
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b0, dat(17));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, dat(300 + i));
    chk("frz_cnt", 64'(count), 64'd17);
    do_reset();
    step(1'b1, 1'b0, 1'b1, '0);
    chk("post_rst_udf", 64'(udf), 64'd1);

`ifdef HFIFO_SKEW_EN
    // One read fans out diagonally: lane k valid exactly 1+k cycles after the RD edge
    do_reset();
    step(1'b1, 1'b1, 1'b0, dat(0));
    en = 1'b1; wr = 1'b0; rd = 1'b1;
    for (int c = 1; c <= NCH + 1; c++) begin
      @(posedge clk);
      #1;
      rd = 1'b0;
      chk("skew_vld", 64'(valid_o), (c <= NCH) ? (64'd1 << (c - 1)) : 64'd0);
      if (c <= NCH)
        chk("skew_dat", 64'(dout[(c-1)*WIDTH +: WIDTH]), 64'(1 + (c - 1) * 256));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
